cordic_rotator: RTL and testbench



---
 rtl/cordic_pkg.sv | 28 ++
 rtl/cordic_micro_rot.sv | 50 +++++
 rtl/cordic_rotator.sv | 119 +++++++++++
 tb/tb_cordic_rotator.sv | 377 +++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/cordic_pkg.sv
// Shared definitions for the CORDIC rotation engine: controller state
// encoding, the arctangent table and the gain seen by the downstream stage.
package cordic_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ROTATE = 2'd1,
    DONE   = 2'd2
  } state_t;

  // atan(2^-i) as a binary angle with pi = 2^31. Users round it down to
  // their own angle width.
  localparam logic [31:0] ATAN_TABLE [32] = '{
    32'h2000_0000, 32'h12E4_051E, 32'h09FB_385B, 32'h0511_11D4,
    32'h028B_0D43, 32'h0145_D7E1, 32'h00A2_F61E, 32'h0051_7C55,
    32'h0028_BE53, 32'h0014_5F2F, 32'h000A_2F98, 32'h0005_17CC,
    32'h0002_8BE6, 32'h0001_45F3, 32'h0000_A2FA, 32'h0000_517D,
    32'h0000_28BE, 32'h0000_145F, 32'h0000_0A30, 32'h0000_0518,
    32'h0000_028C, 32'h0000_0146, 32'h0000_00A3, 32'h0000_0051,
    32'h0000_0029, 32'h0000_0014, 32'h0000_000A, 32'h0000_0005,
    32'h0000_0003, 32'h0000_0001, 32'h0000_0001, 32'h0000_0000
  };

  // Gain carried by x_out/y_out (limit for many iterations). The MultK
  // stage after this block multiplies by 1/CORDIC_GAIN.
  localparam real CORDIC_GAIN = 1.6467602581;

endpackage

// File: rtl/cordic_micro_rot.sv
// One CORDIC micro-rotation: given the current x/y/z and the iteration
// index, produce the next x/y/z. Purely combinational.
module cordic_micro_rot
  import cordic_pkg::*;
#(
  parameter int BITS = 16,
  parameter int CW   = 4
) (
  input  logic signed [BITS+1:0] x,
  input  logic signed [BITS+1:0] y,
  input  logic        [BITS-1:0] z,
  input  logic        [CW-1:0]   iter,
  output logic signed [BITS+1:0] x_next,
  output logic signed [BITS+1:0] y_next,
  output logic        [BITS-1:0] z_next
);

  localparam int W = BITS + 2;

  // Shared adder/subtractor: a - b when sub is set, otherwise a + b.
  function automatic logic signed [W-1:0] add_sub(input logic signed [W-1:0] a,
                                                  input logic signed [W-1:0] b,
                                                  input logic            sub);
    return sub ? a - b : a + b;
  endfunction

  // Arctangent for iteration idx, rounded from the 32-bit table to BITS bits.
  function automatic logic [BITS-1:0] atan_at(input logic [4:0] idx);
    logic [32:0] acc;
    acc = {1'b0, ATAN_TABLE[idx]};
    if (BITS < 32) acc = acc + (33'd1 << (31 - BITS));
    return BITS'(acc >> (32 - BITS));
  endfunction

  logic                d;       // 1: rotate by +atan, 0: rotate by -atan
  logic signed [W-1:0] x_sh;
  logic signed [W-1:0] y_sh;
  logic [BITS-1:0]     atan_i;

  assign d      = ~z[BITS-1];
  assign x_sh   = x >>> iter;
  assign y_sh   = y >>> iter;
  assign atan_i = atan_at(5'(iter));

  assign x_next = add_sub(x, y_sh, d);
  assign y_next = add_sub(y, x_sh, ~d);
  // z lives in BITS bits and wraps modulo 2^BITS; the extra adder bits drop.
  assign z_next = BITS'(add_sub({2'b00, z}, {2'b00, atan_i}, d));

endmodule

// File: rtl/cordic_rotator.sv
// Iterative CORDIC rotator: accepts (x, y, z), pre-rotates by pi when z lies
// outside [-pi/2, pi/2), then applies one micro-rotation per clock. Results
// carry the CORDIC gain and are held until the consumer takes them.
module cordic_rotator
  import cordic_pkg::*;
#(
  parameter int BITS  = 16,
  parameter int ITERS = 12
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [BITS-1:0] x_in,
  input  logic [BITS-1:0] y_in,
  input  logic [BITS-1:0] z_in,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [BITS+1:0] x_out,
  output logic [BITS+1:0] y_out
);

  localparam int CW = (BITS > 1) ? $clog2(BITS) : 1;
  localparam int W  = BITS + 2;

  state_t              state;
  state_t              state_next;
  logic signed [W-1:0] x_q;
  logic signed [W-1:0] y_q;
  logic [BITS-1:0]     z_q;
  logic [CW-1:0]       cnt;

  logic signed [W-1:0] x_nx;
  logic signed [W-1:0] y_nx;
  logic [BITS-1:0]     z_nx;
  logic signed [W-1:0] x_ext;
  logic signed [W-1:0] y_ext;
  logic signed [W-1:0] x_load;
  logic signed [W-1:0] y_load;
  logic [BITS-1:0]     z_load;
  logic                accept;
  logic                last_iter;
  logic                flip;

  // Handshake flags are pure state decodes: no path from in_valid/out_ready.
  assign in_ready  = (state == IDLE);
  assign out_valid = (state == DONE);
  assign accept    = in_valid && in_ready;
  assign last_iter = (cnt == CW'(ITERS - 1));

  // Quadrant pre-rotation: angles in [pi/2, pi) or [-pi, -pi/2) get pi added
  // and the vector negated, leaving the residual inside CORDIC convergence.
  // Two guard bits keep -(-2^(BITS-1)) and the gain growth from overflowing.
  assign flip   = z_in[BITS-1] ^ z_in[BITS-2];
  assign x_ext  = {{2{x_in[BITS-1]}}, x_in};
  assign y_ext  = {{2{y_in[BITS-1]}}, y_in};
  assign x_load = flip ? -x_ext : x_ext;
  assign y_load = flip ? -y_ext : y_ext;
  assign z_load = flip ? {~z_in[BITS-1], z_in[BITS-2:0]} : z_in;

  cordic_micro_rot #(
    .BITS (BITS),
    .CW   (CW)
  ) u_micro_rot (
    .x      (x_q),
    .y      (y_q),
    .z      (z_q),
    .iter   (cnt),
    .x_next (x_nx),
    .y_next (y_nx),
    .z_next (z_nx)
  );

  // Controller state register.
  // NOTE: sequential state always uses non-blocking (<=) so every register
  // samples pre-edge values; blocking here would create ordering races.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_next;
  end

  // Next-state decode: IDLE -> ROTATE -> DONE -> IDLE.
  // NOTE: state_next gets a default before the case so every path assigns
  // it; a missing assignment would infer a latch.
  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (accept)    state_next = ROTATE;
      ROTATE:  if (last_iter) state_next = DONE;
      DONE:    if (out_ready) state_next = IDLE;
      default:                state_next = IDLE;
    endcase
  end

  // Datapath: load on accept, one micro-rotation per ROTATE cycle, hold
  // otherwise so the result stays stable through DONE.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      x_q <= '0;
      y_q <= '0;
      z_q <= '0;
      cnt <= '0;
    end else if (accept) begin
      x_q <= x_load;
      y_q <= y_load;
      z_q <= z_load;
      cnt <= '0;
    end else if (state == ROTATE) begin
      x_q <= x_nx;
      y_q <= y_nx;
      z_q <= z_nx;
      if (!last_iter) cnt <= cnt + 1'b1;
    end
  end

  assign x_out = x_q;
  assign y_out = y_q;

endmodule

// File: tb/tb_cordic_rotator.sv
// Self-checking bench for cordic_rotator (BITS=16, ITERS=12). Expected x/y
// come from a floating-point model: the angle is decomposed greedily into
// +/-atan(2^-i) steps, the vector is rotated by the exact sum and scaled by
// the gain of ITERS iterations.
module tb_cordic_rotator;
  import cordic_pkg::*;

  localparam int BITS  = 16;
  localparam int ITERS = 12;
  localparam int W     = BITS + 2;
  localparam real PI   = 3.14159265358979323846;
  // Shift truncation can cost up to about one LSB per shifted iteration on
  // top of the nominal tolerance.
  localparam real TOL_DIR  = 4.0 + (ITERS - 1);
  localparam real TOL_RAND = 6.0 + (ITERS - 1);

  logic            clk = 1'b0;
  logic            rst_n;
  logic            in_valid;
  logic            in_ready;
  logic [BITS-1:0] x_in;
  logic [BITS-1:0] y_in;
  logic [BITS-1:0] z_in;
  logic            out_valid;
  logic            out_ready;
  logic [W-1:0]    x_out;
  logic [W-1:0]    y_out;

  int  checks   = 0;
  int  failures = 0;
  real k_gain;
  int  atan16 [ITERS];

  cordic_rotator #(
    .BITS  (BITS),
    .ITERS (ITERS)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .x_in      (x_in),
    .y_in      (y_in),
    .z_in      (z_in),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .x_out     (x_out),
    .y_out     (y_out)
  );

  always #5 clk = ~clk;

  function automatic void init_model();
    k_gain = 1.0;
    for (int i = 0; i < ITERS; i++) begin
      k_gain    = k_gain * $sqrt(1.0 + 1.0 / (4.0 ** i));
      atan16[i] = $rtoi($atan(1.0 / (2.0 ** i)) / PI * 32768.0 + 0.5);
    end
  endfunction

  function automatic void model(input int x, input int y, input int z,
                                output real ex, output real ey);
    int  zz;
    int  xs;
    int  ys;
    real ang;
    zz  = z & 32'hFFFF;
    xs  = x;
    ys  = y;
    ang = 0.0;
    if (zz[15] != zz[14]) begin
      xs = -x;
      ys = -y;
      zz = zz ^ 32'h8000;
    end
    for (int i = 0; i < ITERS; i++) begin
      if (!zz[15]) begin
        ang = ang + $atan(1.0 / (2.0 ** i));
        zz  = (zz - atan16[i]) & 32'hFFFF;
      end else begin
        ang = ang - $atan(1.0 / (2.0 ** i));
        zz  = (zz + atan16[i]) & 32'hFFFF;
      end
    end
    ex = k_gain * (xs * $cos(ang) - ys * $sin(ang));
    ey = k_gain * (ys * $cos(ang) + xs * $sin(ang));
  endfunction

  function automatic int sx(input logic [W-1:0] v);
    return int'($signed(v));
  endfunction

  // Present one sample, wait for accept, then count edges to out_valid.
  // Leaves the DUT in IDLE if out_ready is high, otherwise parked in DONE.
  task automatic send(input int x, input int y, input int z,
                      output int lat, output int xo, output int yo);
    int guard;
    x_in     = BITS'(x);
    y_in     = BITS'(y);
    z_in     = BITS'(z);
    in_valid = 1'b1;
    guard    = 0;
    while (!in_ready && guard < 100) begin
      @(posedge clk); #1;
      guard++;
    end
    @(posedge clk); #1;
    in_valid = 1'b0;
    lat = 0;
    while (!out_valid && lat < 100) begin
      @(posedge clk); #1;
      lat++;
    end
    xo = sx(x_out);
    yo = sx(y_out);
    if (out_ready) begin
      @(posedge clk); #1;
    end
  endtask

  task automatic test_reset();
    rst_n     = 1'b0;
    in_valid  = 1'b0;
    out_ready = 1'b1;
    x_in      = '0;
    y_in      = '0;
    z_in      = '0;
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if (out_valid !== 1'b0 || x_out !== '0 || y_out !== '0) begin
      failures++;
      $display("FAIL reset_outputs: out_valid=%b x_out=%0d y_out=%0d, required 0 0 0",
               out_valid, sx(x_out), sx(y_out));
    end
    #3 rst_n = 1'b1;
    #1;
    checks++;
    if (in_ready !== 1'b1) begin
      failures++;
      $display("FAIL reset_in_ready: got %b, required 1", in_ready);
    end
    @(posedge clk); #1;
  endtask

  task automatic test_directed();
    int  vx [3] = '{16384, 10000, 10000};
    int  vy [3] = '{0, 0, 0};
    int  vz [3] = '{0, 16384, -32768};
    int  lat, xo, yo;
    real ex, ey;
    for (int t = 0; t < 3; t++) begin
      model(vx[t], vy[t], vz[t], ex, ey);
      send(vx[t], vy[t], vz[t], lat, xo, yo);
      checks++;
      if (lat != ITERS) begin
        failures++;
        $display("FAIL directed%0d_latency: got %0d edges, required %0d", t, lat, ITERS);
      end
      checks++;
      if (xo - ex > TOL_DIR || ex - xo > TOL_DIR) begin
        failures++;
        $display("FAIL directed%0d_x: got %0d, required %0.1f +/- %0.1f", t, xo, ex, TOL_DIR);
      end
      checks++;
      if (yo - ey > TOL_DIR || ey - yo > TOL_DIR) begin
        failures++;
        $display("FAIL directed%0d_y: got %0d, required %0.1f +/- %0.1f", t, yo, ey, TOL_DIR);
      end
    end
  endtask

  task automatic test_done_hold();
    int  lat, xo, yo, n;
    real ex, ey;
    out_ready = 1'b0;
    send(5000, -3000, 9000, lat, xo, yo);
    checks++;
    if (lat != ITERS) begin
      failures++;
      $display("FAIL hold_latency: got %0d, required %0d", lat, ITERS);
    end
    // A new sample offered during DONE must be ignored until IDLE.
    model(-7000, 2000, -20000, ex, ey);
    x_in     = BITS'(-7000);
    y_in     = BITS'(2000);
    z_in     = BITS'(-20000);
    in_valid = 1'b1;
    for (int c = 0; c < 5; c++) begin
      @(posedge clk); #1;
      checks++;
      if (out_valid !== 1'b1 || in_ready !== 1'b0 || sx(x_out) != xo || sx(y_out) != yo) begin
        failures++;
        $display("FAIL hold_stable_c%0d: out_valid=%b in_ready=%b x=%0d y=%0d, required 1 0 %0d %0d",
                 c, out_valid, in_ready, sx(x_out), sx(y_out), xo, yo);
      end
    end
    out_ready = 1'b1;
    @(posedge clk); #1;
    checks++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
      failures++;
      $display("FAIL hold_release: out_valid=%b in_ready=%b, required 0 1", out_valid, in_ready);
    end
    // in_valid still high: accepted on this edge, not the DONE exit edge.
    @(posedge clk); #1;
    in_valid = 1'b0;
    checks++;
    if (in_ready !== 1'b0) begin
      failures++;
      $display("FAIL hold_reaccept: in_ready=%b, required 0", in_ready);
    end
    n = 0;
    while (!out_valid && n < 100) begin
      @(posedge clk); #1;
      n++;
    end
    checks++;
    if (n != ITERS || xo == sx(x_out) && yo == sx(y_out)
        || sx(x_out) - ex > TOL_DIR || ex - sx(x_out) > TOL_DIR
        || sx(y_out) - ey > TOL_DIR || ey - sx(y_out) > TOL_DIR) begin
      failures++;
      $display("FAIL hold_second_sample: lat=%0d x=%0d y=%0d, required lat %0d x %0.1f y %0.1f",
               n, sx(x_out), sx(y_out), ITERS, ex, ey);
    end
    @(posedge clk); #1;
  endtask

  task automatic test_reset_mid();
    int  lat, xo, yo;
    bit  spurious;
    real ex, ey;
    x_in     = BITS'(12000);
    y_in     = BITS'(7000);
    z_in     = BITS'(3000);
    in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    checks++;
    if (in_ready !== 1'b0) begin
      failures++;
      $display("FAIL rotate_in_ready: got %b, required 0", in_ready);
    end
    repeat (6) @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if (out_valid !== 1'b0 || x_out !== '0 || y_out !== '0 || in_ready !== 1'b1) begin
      failures++;
      $display("FAIL midreset_outputs: out_valid=%b x=%0d y=%0d in_ready=%b, required 0 0 0 1",
               out_valid, sx(x_out), sx(y_out), in_ready);
    end
    #2 rst_n = 1'b1;
    spurious = 1'b0;
    for (int c = 0; c < 2 * ITERS + 4; c++) begin
      @(posedge clk); #1;
      if (out_valid) spurious = 1'b1;
    end
    checks++;
    if (spurious) begin
      failures++;
      $display("FAIL midreset_no_out_valid: out_valid seen after reset, required none");
    end
    model(-9000, 11000, 25000, ex, ey);
    send(-9000, 11000, 25000, lat, xo, yo);
    checks++;
    if (lat != ITERS || xo - ex > TOL_DIR || ex - xo > TOL_DIR
        || yo - ey > TOL_DIR || ey - yo > TOL_DIR) begin
      failures++;
      $display("FAIL midreset_recover: lat=%0d x=%0d y=%0d, required lat %0d x %0.1f y %0.1f",
               lat, xo, yo, ITERS, ex, ey);
    end
  endtask

  task automatic test_random();
    int  x, y, z, lat, xo, yo;
    real ex, ey;
    out_ready = 1'b1;
    for (int t = 0; t < 200; t++) begin
      x = int'($urandom_range(32000)) - 16000;
      y = int'($urandom_range(32000)) - 16000;
      z = int'($urandom_range(65535));
      model(x, y, z, ex, ey);
      send(x, y, z, lat, xo, yo);
      checks++;
      if (lat != ITERS || xo - ex > TOL_RAND || ex - xo > TOL_RAND
          || yo - ey > TOL_RAND || ey - yo > TOL_RAND) begin
        failures++;
        $display("FAIL random%0d: in=(%0d,%0d,%0d) lat=%0d got (%0d,%0d), required (%0.1f,%0.1f) +/- %0.1f",
                 t, x, y, z, lat, xo, yo, ex, ey, TOL_RAND);
      end
    end
  endtask

  task automatic test_back_to_back();
    localparam int N = 4;
    int  sx_v [N];
    int  sy_v [N];
    int  sz_v [N];
    real qx [$];
    real qy [$];
    real ex, ey;
    int  sent, got, cyc, prev_rise;
    bit  ready_before;
    for (int i = 0; i < N; i++) begin
      sx_v[i] = int'($urandom_range(30000)) - 15000;
      sy_v[i] = int'($urandom_range(30000)) - 15000;
      sz_v[i] = int'($urandom_range(65535));
    end
    out_ready = 1'b1;
    sent      = 0;
    got       = 0;
    prev_rise = -1;
    x_in      = BITS'(sx_v[0]);
    y_in      = BITS'(sy_v[0]);
    z_in      = BITS'(sz_v[0]);
    in_valid  = 1'b1;
    for (cyc = 0; cyc < 20 * N && got < N; cyc++) begin
      ready_before = in_ready;
      @(posedge clk); #1;
      if (ready_before && in_valid) begin
        model(sx_v[sent], sy_v[sent], sz_v[sent], ex, ey);
        qx.push_back(ex);
        qy.push_back(ey);
        sent++;
        if (sent < N) begin
          x_in = BITS'(sx_v[sent]);
          y_in = BITS'(sy_v[sent]);
          z_in = BITS'(sz_v[sent]);
        end else begin
          in_valid = 1'b0;
        end
      end
      if (out_valid) begin
        ex = (qx.size() > 0) ? qx.pop_front() : 0.0;
        ey = (qy.size() > 0) ? qy.pop_front() : 0.0;
        checks++;
        if (sx(x_out) - ex > TOL_RAND || ex - sx(x_out) > TOL_RAND
            || sx(y_out) - ey > TOL_RAND || ey - sx(y_out) > TOL_RAND) begin
          failures++;
          $display("FAIL b2b_value%0d: got (%0d,%0d), required (%0.1f,%0.1f)",
                   got, sx(x_out), sx(y_out), ex, ey);
        end
        if (prev_rise >= 0) begin
          checks++;
          if (cyc - prev_rise != ITERS + 2) begin
            failures++;
            $display("FAIL b2b_period%0d: got %0d cycles, required %0d",
                     got, cyc - prev_rise, ITERS + 2);
          end
        end
        prev_rise = cyc;
        got++;
      end
    end
    in_valid = 1'b0;
    checks++;
    if (got != N) begin
      failures++;
      $display("FAIL b2b_count: got %0d results, required %0d", got, N);
    end
  endtask

  initial begin
    init_model();
    $display("model gain %0.6f (package nominal %0.6f)", k_gain, CORDIC_GAIN);
    test_reset();
    test_directed();
    test_done_hold();
    test_reset_mid();
    test_random();
    test_back_to_back();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
